// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT control FSM
// with memory-wait timeout, sticky status flags and a retired-instruction counter.
module multicycle_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_sel,
    output logic        ir_load,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mux2,
    output logic        mux3,
    output logic [2:0]  alu_op,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        mem_timeout,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_CBZ
    } class_t;

    localparam logic [9:0] OP_HLT = 10'b1111111111;

    state_t      state_q;
    class_t      class_q;
    logic [3:0]  wait_q;
    logic [15:0] count_q;
    logic        halted_q, illegal_q, timeout_q;

    function automatic class_t decode_class(input logic [9:0] op);
        if (op[9:2] == 8'b10110100) return C_CBZ;
        case (op)
            10'b1000101100: return C_ADD;
            10'b1100101100: return C_SUB;
            10'b1000101000: return C_AND;
            10'b1010101000: return C_ORR;
            10'b1111100001: return C_LDUR;
            10'b1111100000: return C_STUR;
            default:        return C_NONE;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            class_q   <= C_NONE;
            wait_q    <= '0;
            count_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Assigned every cycle so the register always tracks its own value.
            count_q <= count_q + {15'd0, pc_write};
            wait_q  <= '0;
            case (state_q)
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        if (state_q == S_FETCH)       state_q <= S_DECODE;
                        else if (class_q == C_LDUR)   state_q <= S_WB;
                        else if (class_q == C_STUR)   state_q <= S_FETCH;
                        else begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                    end else if (wait_q == 4'd15) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                S_DECODE: begin
                    class_q <= decode_class(opcode);
                    if (opcode == OP_HLT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (decode_class(opcode) == C_NONE) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (class_q)
                        C_ADD, C_SUB, C_AND, C_ORR: state_q <= S_WB;
                        C_LDUR, C_STUR:             state_q <= S_MEM;
                        C_CBZ:                      state_q <= S_FETCH;
                        default: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                    endcase
                end
                S_WB:   state_q <= S_FETCH;
                S_HALT: state_q <= S_HALT;
                default: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_sel   = 1'b0;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        mux2      = 1'b0;
        mux3      = 1'b0;
        alu_op    = 3'b000;
        // Reset silences all strobes immediately, even mid-transaction.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_load  = mem_ready;
                end
                S_EXEC: begin
                    case (class_q)
                        C_ADD: alu_op = 3'b010;
                        C_SUB: alu_op = 3'b110;
                        C_AND: alu_op = 3'b000;
                        C_ORR: alu_op = 3'b001;
                        C_LDUR, C_STUR: begin
                            alu_op = 3'b010;
                            mux3   = 1'b1;
                        end
                        C_CBZ: begin
                            alu_op   = 3'b111;
                            pc_write = 1'b1;
                            pc_src   = zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_sel   = 1'b1;
                    mem_read  = (class_q == C_LDUR);
                    mem_write = (class_q == C_STUR);
                    pc_write  = (class_q == C_STUR) && mem_ready;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    mux2      = (class_q == C_LDUR);
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state       = reset ? 3'd0 : state_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: stimulus pushes hand-derived
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [9:0]  opcode;
    logic        mem_read, mem_write, mem_sel, ir_load, pc_write, pc_src;
    logic        reg_write, mux2, mux3, halted, illegal, mem_timeout;
    logic [2:0]  alu_op, state;
    logic [15:0] instr_count;

    multicycle_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_sel(mem_sel), .ir_load(ir_load),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mux2(mux2),
        .mux3(mux3), .alu_op(alu_op), .state(state), .halted(halted), .illegal(illegal),
        .mem_timeout(mem_timeout), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] OP_ADD  = 10'b1000101100;
    localparam logic [9:0] OP_SUB  = 10'b1100101100;
    localparam logic [9:0] OP_AND  = 10'b1000101000;
    localparam logic [9:0] OP_ORR  = 10'b1010101000;
    localparam logic [9:0] OP_LDUR = 10'b1111100001;
    localparam logic [9:0] OP_STUR = 10'b1111100000;
    localparam logic [9:0] OP_CBZ  = 10'b1011010011;
    localparam logic [9:0] OP_HLT  = 10'b1111111111;
    localparam logic [9:0] JUNK    = 10'b0000000000;

    // Strobe bits: {mem_read, mem_write, mem_sel, ir_load, pc_write, pc_src, reg_write, mux2, mux3}
    localparam logic [8:0] SB_NONE    = 9'b000000000;
    localparam logic [8:0] SB_F_RDY   = 9'b100100000;
    localparam logic [8:0] SB_F_WAIT  = 9'b100000000;
    localparam logic [8:0] SB_EX_MEM  = 9'b000000001;
    localparam logic [8:0] SB_CBZ_T   = 9'b000011000;
    localparam logic [8:0] SB_CBZ_N   = 9'b000010000;
    localparam logic [8:0] SB_LD      = 9'b101000000;
    localparam logic [8:0] SB_ST_WAIT = 9'b011000000;
    localparam logic [8:0] SB_ST_DONE = 9'b011010000;
    localparam logic [8:0] SB_WB      = 9'b000010100;
    localparam logic [8:0] SB_WB_LD   = 9'b000010110;

    // Flags: {halted, illegal, mem_timeout}
    typedef struct {
        string       nm;
        logic [33:0] v;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [33:0] got;
    int          n_checks = 0;
    int          n_pass   = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            got = {state, mem_read, mem_write, mem_sel, ir_load, pc_write, pc_src,
                   reg_write, mux2, mux3, alu_op, halted, illegal, mem_timeout, instr_count};
            n_checks++;
            if (got === cur.v) n_pass++;
            else $display("FAIL %s: got st=%0d stb=%b alu=%b fl=%b cnt=%h, want st=%0d stb=%b alu=%b fl=%b cnt=%h",
                          cur.nm, got[33:31], got[30:22], got[21:19], got[18:16], got[15:0],
                          cur.v[33:31], cur.v[30:22], cur.v[21:19], cur.v[18:16], cur.v[15:0]);
        end
    end

    task automatic push_exp(input string nm, input logic [2:0] st, input logic [8:0] stb,
                            input logic [2:0] alu, input logic [2:0] fl, input logic [15:0] cnt);
        exp_t e;
        e.nm = nm;
        e.v  = {st, stb, alu, fl, cnt};
        exp_q.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic rst, input logic [9:0] op, input logic z,
                       input logic rdy, input logic [2:0] st, input logic [8:0] stb,
                       input logic [2:0] alu, input logic [2:0] fl, input logic [15:0] cnt);
        @(posedge clk);
        #1;
        reset = rst; opcode = op; zero = z; mem_ready = rdy;
        push_exp(nm, st, stb, alu, fl, cnt);
    endtask

    task automatic fetch_dec(input string nm, input logic [9:0] op, input logic [15:0] cnt);
        cyc({nm, "_fetch"},  1'b0, JUNK, 1'b0, 1'b1, 3'd0, SB_F_RDY, 3'b000, 3'b000, cnt);
        cyc({nm, "_decode"}, 1'b0, op,   1'b0, 1'b1, 3'd1, SB_NONE,  3'b000, 3'b000, cnt);
    endtask

    task automatic run_r(input string nm, input logic [9:0] op, input logic [2:0] alu,
                         input logic [15:0] cnt);
        fetch_dec(nm, op, cnt);
        cyc({nm, "_exec"}, 1'b0, JUNK, 1'b1, 1'b1, 3'd2, SB_NONE, alu,    3'b000, cnt);
        cyc({nm, "_wb"},   1'b0, JUNK, 1'b0, 1'b1, 3'd4, SB_WB,   3'b000, 3'b000, cnt);
    endtask

    task automatic run_ld(input string nm, input int waits, input logic [15:0] cnt);
        fetch_dec(nm, OP_LDUR, cnt);
        cyc({nm, "_exec"}, 1'b0, JUNK, 1'b0, 1'b1, 3'd2, SB_EX_MEM, 3'b010, 3'b000, cnt);
        for (int i = 0; i < waits; i++)
            cyc({nm, "_mem_wait"}, 1'b0, JUNK, 1'b0, 1'b0, 3'd3, SB_LD, 3'b000, 3'b000, cnt);
        cyc({nm, "_mem_done"}, 1'b0, JUNK, 1'b0, 1'b1, 3'd3, SB_LD,    3'b000, 3'b000, cnt);
        cyc({nm, "_wb"},       1'b0, JUNK, 1'b0, 1'b1, 3'd4, SB_WB_LD, 3'b000, 3'b000, cnt);
    endtask

    task automatic run_st(input string nm, input int waits, input logic [15:0] cnt);
        fetch_dec(nm, OP_STUR, cnt);
        cyc({nm, "_exec"}, 1'b0, JUNK, 1'b0, 1'b1, 3'd2, SB_EX_MEM, 3'b010, 3'b000, cnt);
        for (int i = 0; i < waits; i++)
            cyc({nm, "_mem_wait"}, 1'b0, JUNK, 1'b0, 1'b0, 3'd3, SB_ST_WAIT, 3'b000, 3'b000, cnt);
        cyc({nm, "_mem_done"}, 1'b0, JUNK, 1'b0, 1'b1, 3'd3, SB_ST_DONE, 3'b000, 3'b000, cnt);
    endtask

    task automatic run_cbz(input string nm, input logic z, input logic [15:0] cnt);
        fetch_dec(nm, OP_CBZ, cnt);
        cyc({nm, "_exec"}, 1'b0, JUNK, z, 1'b1, 3'd2, z ? SB_CBZ_T : SB_CBZ_N, 3'b111, 3'b000, cnt);
    endtask

    initial begin
        reset = 1'b1; opcode = JUNK; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        cyc("reset_state", 1'b1, JUNK, 1'b0, 1'b1, 3'd0, SB_NONE, 3'b000, 3'b000, 16'd0);

        run_r("add", OP_ADD, 3'b010, 16'd0);
        run_r("sub", OP_SUB, 3'b110, 16'd1);
        run_r("and", OP_AND, 3'b000, 16'd2);
        run_r("orr", OP_ORR, 3'b001, 16'd3);
        run_ld("ldur_wait3", 3, 16'd4);
        run_st("stur", 0, 16'd5);
        run_st("stur_wait1", 1, 16'd6);
        run_cbz("cbz_taken", 1'b1, 16'd7);
        run_cbz("cbz_not_taken", 1'b0, 16'd8);

        // Fifteen low cycles in FETCH, ready on the 16th still completes.
        for (int i = 0; i < 15; i++)
            cyc("fetch_wait15", 1'b0, JUNK, 1'b0, 1'b0, 3'd0, SB_F_WAIT, 3'b000, 3'b000, 16'd9);
        run_r("add_after_wait", OP_ADD, 3'b010, 16'd9);

        // Reset in the middle of an LDUR memory wait.
        fetch_dec("ldur_rst", OP_LDUR, 16'd10);
        cyc("ldur_rst_exec", 1'b0, JUNK, 1'b0, 1'b1, 3'd2, SB_EX_MEM, 3'b010, 3'b000, 16'd10);
        repeat (2) cyc("ldur_rst_mem", 1'b0, JUNK, 1'b0, 1'b0, 3'd3, SB_LD, 3'b000, 3'b000, 16'd10);
        cyc("reset_mid_mem", 1'b1, JUNK, 1'b0, 1'b0, 3'd0, SB_NONE, 3'b000, 3'b000, 16'd10);

        // Sixteen low cycles in FETCH time out into HALT.
        for (int i = 0; i < 16; i++)
            cyc("fetch_timeout", 1'b0, JUNK, 1'b0, 1'b0, 3'd0, SB_F_WAIT, 3'b000, 3'b000, 16'd0);
        for (int i = 0; i < 4; i++)
            cyc("timeout_halt", 1'b0, OP_ADD, 1'b1, 1'b1, 3'd5, SB_NONE, 3'b000, 3'b101, 16'd0);
        cyc("reset_from_timeout", 1'b1, JUNK, 1'b0, 1'b1, 3'd0, SB_NONE, 3'b000, 3'b101, 16'd0);

        // Illegal opcode, then HALT holds with strobes quiet for 20 cycles.
        fetch_dec("illegal", JUNK, 16'd0);
        for (int i = 0; i < 20; i++)
            cyc("illegal_halt", 1'b0, OP_LDUR, i[1], i[0], 3'd5, SB_NONE, 3'b000, 3'b110, 16'd0);
        cyc("reset_from_illegal", 1'b1, JUNK, 1'b0, 1'b1, 3'd0, SB_NONE, 3'b000, 3'b110, 16'd0);

        fetch_dec("hlt", OP_HLT, 16'd0);
        for (int i = 0; i < 3; i++)
            cyc("hlt_halt", 1'b0, OP_STUR, 1'b0, 1'b1, 3'd5, SB_NONE, 3'b000, 3'b100, 16'd0);
        cyc("reset_from_hlt", 1'b1, JUNK, 1'b0, 1'b1, 3'd0, SB_NONE, 3'b000, 3'b100, 16'd0);

        // Preload the retire counter to 0xFFFF, then retire one ADD.
        @(posedge clk);
        #1;
        reset = 1'b0; opcode = JUNK; zero = 1'b0; mem_ready = 1'b0;
        force dut.count_q = 16'hFFFF;
        push_exp("preload_ffff", 3'd0, SB_F_WAIT, 3'b000, 3'b000, 16'hFFFF);
        @(posedge clk);
        #1;
        release dut.count_q;
        mem_ready = 1'b1;
        push_exp("wrap_fetch", 3'd0, SB_F_RDY, 3'b000, 3'b000, 16'hFFFF);
        cyc("wrap_decode", 1'b0, OP_ADD, 1'b0, 1'b1, 3'd1, SB_NONE, 3'b000, 3'b000, 16'hFFFF);
        cyc("wrap_exec",   1'b0, JUNK,   1'b0, 1'b1, 3'd2, SB_NONE, 3'b010, 3'b000, 16'hFFFF);
        cyc("wrap_wb",     1'b0, JUNK,   1'b0, 1'b1, 3'd4, SB_WB,   3'b000, 3'b000, 16'hFFFF);
        cyc("wrap_zero",   1'b0, JUNK,   1'b0, 1'b0, 3'd0, SB_F_WAIT, 3'b000, 3'b000, 16'h0000);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
